// File: rtl/shift_operand_stage.sv
// Operand/decode stage feeding the RV32I barrel shifters.
// Decodes SLL/SRL/SRA(I), buffers up to two entries behind a valid/ready pair.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   flush           synchronous kill of all buffered entries
//   in_valid/ready  upstream handshake; instr, rs1_data, rs2_data payload
//   out_valid/ready downstream handshake
//   out_data        operand to shift (rs1_data, 0 if illegal)
//   out_shamt       shift amount
//   out_op          00 SLL, 01 SRL, 11 SRA
//   out_rd          destination register
//   out_wr_en       legal and rd != 0
//   out_illegal     instruction is not a legal shift
module shift_operand_stage #(
  parameter int SKID = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_shamt,
  output logic [1:0]  out_op,
  output logic [4:0]  out_rd,
  output logic        out_wr_en,
  output logic        out_illegal
);

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic        wr_en;
    logic        illegal;
  } entry_t;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] F7_Z  = 7'b0000000;
  localparam logic [6:0] F7_A  = 7'b0100000;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_r;
  logic       is_i;
  logic       sel_sll;
  logic       sel_srl;
  logic       sel_sra;
  logic       legal;
  entry_t     dec;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign is_r = (opc == OPC_R);
  assign is_i = (opc == OPC_I);

  // The immediate form has the same funct7 position,
  // so imm[5]=1 on a shift-immediate lands here as illegal.
  assign sel_sll = (f3 == 3'b001) && (f7 == F7_Z);
  assign sel_srl = (f3 == 3'b101) && (f7 == F7_Z);
  assign sel_sra = (f3 == 3'b101) && (f7 == F7_A);

  assign legal = (is_r || is_i)
              && (sel_sll || sel_srl || sel_sra);

  always_comb begin
    dec         = '0;
    dec.rd      = instr[11:7];
    dec.illegal = !legal;
    dec.wr_en   = legal && (instr[11:7] != 5'd0);
    if (legal) begin
      dec.data  = rs1_data;
      dec.shamt = is_r ? rs2_data[4:0]
                       : instr[24:20];
      unique case (1'b1)
        sel_sll: dec.op = 2'b00;
        sel_srl: dec.op = 2'b01;
        sel_sra: dec.op = 2'b11;
        default: dec.op = 2'b00;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{instr[19:15], rs2_data[31:5]};

  entry_t main_q;
  logic   main_v;

  if (SKID != 0) begin : g_skid

    typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
    } state_e;

    state_e st_q;
    entry_t skid_q;
    logic   rdy_q;
    logic   acc;
    logic   cons;

    // in_ready comes straight from rdy_q; no path from out_ready.
    assign acc    = in_valid && rdy_q;
    assign cons   = out_ready && (st_q != EMPTY);
    assign main_v = (st_q != EMPTY);

    assign in_ready = rdy_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q   <= EMPTY;
        rdy_q  <= 1'b1;
        main_q <= '0;
        skid_q <= '0;
      end else if (flush) begin
        st_q  <= EMPTY;
        rdy_q <= 1'b1;
      end else begin
        unique case (st_q)
          EMPTY: begin
            if (acc) begin
              main_q <= dec;
              st_q   <= ONE;
            end
          end
          ONE: begin
            if (acc && cons) begin
              main_q <= dec;
            end else if (acc) begin
              skid_q <= dec;
              st_q   <= FULL;
              rdy_q  <= 1'b0;
            end else if (cons) begin
              st_q <= EMPTY;
            end
          end
          FULL: begin
            // rdy_q is low here, so no accept can race this move.
            if (cons) begin
              main_q <= skid_q;
              st_q   <= ONE;
              rdy_q  <= 1'b1;
            end
          end
          default: begin
            st_q  <= EMPTY;
            rdy_q <= 1'b1;
          end
        endcase
      end
    end

  end else begin : g_single

    logic main_v_q;
    logic acc;
    logic cons;

    assign in_ready = !main_v_q || out_ready;
    assign acc      = in_valid && in_ready;
    assign cons     = main_v_q && out_ready;
    assign main_v   = main_v_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_v_q <= 1'b0;
        main_q   <= '0;
      end else if (flush) begin
        main_v_q <= 1'b0;
      end else if (acc) begin
        main_q   <= dec;
        main_v_q <= 1'b1;
      end else if (cons) begin
        main_v_q <= 1'b0;
      end
    end

  end

  assign out_valid   = main_v;
  assign out_data    = main_q.data;
  assign out_shamt   = main_q.shamt;
  assign out_op      = main_q.op;
  assign out_rd      = main_q.rd;
  assign out_wr_en   = main_q.wr_en;
  assign out_illegal = main_q.illegal;

endmodule

// File: doc/shift_operand_stage.md
Name: shift_operand_stage

Overview:
Registered operand/decode stage directly upstream of the 32-bit barrel shifters (SLL/SRL/SRA) in the RV32I datapath.
- Accepts a shift-class instruction plus register-file read data over a valid/ready handshake.
- Decodes the op, selects the shift amount, and presents registered data/shamt/op/rd to the combinational shifter.
- Buffers up to 2 entries so back-pressure from the shifter/writeback side never drops an instruction.

Parameters:
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single output register with in_ready = !out_valid || out_ready.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all buffered entries
in_valid  input  1  upstream presents an instruction
in_ready  output  1  stage can accept this cycle
instr  input  32  raw RV32I instruction word
rs1_data  input  32  value of rs1
rs2_data  input  32  value of rs2
out_valid  output  1  output entry valid
out_ready  input  1  downstream consumes this cycle
out_data  output  32  operand to shift (rs1_data)
out_shamt  output  5  shift amount
out_op  output  2  00 SLL, 01 SRL, 11 SRA, 10 never produced
out_rd  output  5  destination register
out_wr_en  output  1  1 when legal and rd != 0
out_illegal  output  1  instruction not a legal shift

Behaviour:
Transfers:
- Input transfer when in_valid && in_ready.
- Output transfer when out_valid && out_ready.

Decode (combinational on input, registered into the entry):
- R-type: opcode 0110011.
  - funct3=001, funct7=0000000 -> SLL.
  - funct3=101, funct7=0000000 -> SRL.
  - funct3=101, funct7=0100000 -> SRA.
  - shamt = rs2_data[4:0]; upper bits of rs2_data ignored.
- I-type: opcode 0010011.
  - funct3=001, instr[31:25]=0000000 -> SLLI.
  - funct3=101, instr[31:25]=0000000 -> SRLI.
  - funct3=101, instr[31:25]=0100000 -> SRAI.
  - shamt = instr[24:20].
- Anything else (including instr[25]=1 on an immediate shift): illegal=1, op=00, shamt=0, data=0, wr_en=0. The entry is still passed downstream in order.
- rd = instr[11:7]; wr_en = !illegal && rd != 0.

Latency and throughput:
- Accepted in cycle N -> visible on out_* in cycle N+1.
- Sustained 1 instruction/cycle while out_ready=1.

SKID=1 states (main_v, skid_v):
- EMPTY (0,0): accept -> ONE.
- ONE (1,0):
  - accept && consume -> ONE; new entry replaces main.
  - accept && !consume -> FULL; new entry goes to skid.
  - consume && !accept -> EMPTY.
- FULL (1,1):
  - in_ready=0.
  - consume -> ONE; skid moves to main in the same edge.
- in_ready = !skid_v, driven directly from a flop, no combinational path from out_ready.
- out_* always reflect the main entry. Order is strictly FIFO.

SKID=0:
- Single entry. in_ready = !out_valid || out_ready.
- Simultaneous accept+consume replaces the entry.

Hold rule: while out_valid && !out_ready, all out_* remain stable.

flush:
- Next edge clears main_v and skid_v.
- An input presented in the flush cycle is dropped, even if in_ready=1.
- Next cycle: out_valid=0, in_ready=1.

Reset (asynchronous):
- Immediately: out_valid=0, in_ready=1, out_data=0, out_shamt=0, out_op=00, out_rd=0, out_wr_en=0, out_illegal=0.
- Reset mid-transfer discards all entries; the transfer is lost.

Payload fields of an invalid entry hold their last value (don't-care), except that after reset they are 0.

Test Plan:
- SRAI: instr=0x4041D093 (srai x1,x3,4), rs1=0x80000000, accepted at cycle 1 -> cycle 2: out_valid=1, out_op=11, out_shamt=4, out_data=0x80000000, out_rd=1, out_wr_en=1, out_illegal=0.
- SLL register shamt: instr=0x002090B3 (sll x1,x1,x2), rs2=0xFFFFFFE3 -> out_shamt=3, out_op=00. Only rs2[4:0] is used.
- Illegal/rd=0:
  - instr=0x0200D093 (srli with imm[5]=1) -> out_illegal=1, out_wr_en=0, out_shamt=0.
  - srl x0,x1,x2 (0x0020D033) -> out_op=01, out_wr_en=0.
- Back-pressure (SKID=1): 4 back-to-back instructions with out_ready=0 for cycles 2-4.
  - in_ready drops to 0 after 2 accepts.
  - out_* stable throughout.
  - Releasing out_ready drains all 4 in order, none lost or duplicated.
- flush in FULL state with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flush-cycle instruction never appears at the output.
- Async reset asserted mid-cycle while FULL -> out_valid=0 and in_ready=1 before the next clock edge; all payload outputs 0.
